// File: rtl/rll_keyed_stream_lock.sv
// Keyed stream lock: serial key loader with atomic commit, driving per-bit XOR/XNOR key
// gates on a one-stage registered valid/ready stream. A key equal to KEY_POL is transparent.
module rll_keyed_stream_lock #(
  parameter int                   KEY_WIDTH  = 32,
  parameter int                   KEY_CHUNK  = 8,
  parameter int                   DATA_WIDTH = 32,
  parameter logic [KEY_WIDTH-1:0] KEY_POL    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [KEY_CHUNK-1:0]  key_data,
  input  logic                  key_last,
  output logic                  key_armed,
  output logic                  key_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int NB = KEY_WIDTH / KEY_CHUNK;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  typedef enum logic {IDLE, LOAD} load_state_t;

  load_state_t           state, state_nx;
  logic [KEY_WIDTH-1:0]  shadow, shadow_nx, shadow_shifted;
  logic [KEY_WIDTH-1:0]  key_active;
  logic [CW-1:0]         beat_cnt, beat_cnt_nx;
  logic                  commit, load_err;
  logic                  in_fire;
  logic [DATA_WIDTH-1:0] key_mask;

  // The loader never stalls, so every offered beat is taken.
  assign key_ready      = 1'b1;
  assign shadow_shifted = (shadow << KEY_CHUNK) | KEY_WIDTH'(key_data);

  // Stream bit i is gated by key bit (i mod KEY_WIDTH); KEY_POL selects XNOR per bit.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign key_mask[i] = key_active[i % KEY_WIDTH] ^ KEY_POL[i % KEY_WIDTH];
  end

  assign in_ready = key_armed & (~out_valid | out_ready);
  assign in_fire  = in_valid & in_ready;

  // NOTE: every signal gets a default before any branch, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nx    = state;
    shadow_nx   = shadow;
    beat_cnt_nx = beat_cnt;
    commit      = 1'b0;
    load_err    = 1'b0;
    if (key_valid) begin
      if (beat_cnt == LAST_BEAT) begin
        commit      = key_last;
        load_err    = ~key_last;
        state_nx    = IDLE;
        shadow_nx   = '0;
        beat_cnt_nx = '0;
      end else if (key_last) begin
        load_err    = 1'b1;
        state_nx    = IDLE;
        shadow_nx   = '0;
        beat_cnt_nx = '0;
      end else begin
        state_nx    = LOAD;
        shadow_nx   = shadow_shifted;
        beat_cnt_nx = beat_cnt + 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples the
  // pre-edge values; the datapath below therefore still sees the old key in a commit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      beat_cnt   <= '0;
      key_active <= '0;
      key_armed  <= 1'b0;
      key_err    <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      state    <= state_nx;
      shadow   <= shadow_nx;
      beat_cnt <= beat_cnt_nx;
      key_err  <= load_err;
      if (commit) begin
        key_active <= shadow_shifted;
        key_armed  <= 1'b1;
      end
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ key_mask;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rll_keyed_stream_lock.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and a random
// run against a queue-based key/stream reference model on a 32-bit and a 64-bit instance.
module tb_rll_keyed_stream_lock;

  localparam int          NB   = 4;
  localparam logic [31:0] POL1 = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, key_last, in_valid, out_ready;
  logic [7:0]  key_data;
  logic [31:0] in_data0;
  logic [63:0] in_data1;

  logic        key_ready0, key_armed0, key_err0, in_ready0, out_valid0;
  logic [31:0] out_data0;
  logic        key_ready1, key_armed1, key_err1, in_ready1, out_valid1;
  logic [63:0] out_data1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rll_keyed_stream_lock dut0 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready0), .key_data(key_data), .key_last(key_last),
    .key_armed(key_armed0), .key_err(key_err0),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0)
  );

  rll_keyed_stream_lock #(.DATA_WIDTH(64), .KEY_POL(POL1)) dut1 (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready1), .key_data(key_data), .key_last(key_last),
    .key_armed(key_armed1), .key_err(key_err1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1)
  );

  typedef struct {
    logic [31:0] key;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Reference model state
  logic [31:0] m_key;
  logic        m_armed, m_ov, m_err, m_rdy;
  logic [31:0] m_od0;
  logic [63:0] m_od1;
  logic [7:0]  beats[$];

  function automatic logic [63:0] exp64(input logic [63:0] din, input logic [31:0] key);
    return din ^ {2{key ^ POL1}};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer nbeats key beats (MS chunk first); key_last on beat index last_at (-1 = never).
  task automatic load_key(input logic [31:0] key, input int last_at, input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      key_valid = 1'b1;
      key_data  = 8'(key >> (8 * (3 - i)));
      key_last  = (i == last_at);
      tick();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic stream_one(input logic [31:0] d);
    in_valid = 1'b1;
    in_data0 = d;
    in_data1 = {~d, d};
    #1;
    check("stream_in_ready", in_ready0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rx[$];
    logic [31:0] held, w, d, k;
    int          sent;
    logic        acc;

    vecs[0] = '{32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{32'h80000001, 32'h00000000, 32'h80000001};
    vecs[2] = '{32'h80000001, 32'hFFFFFFFF, 32'h7FFFFFFE};
    vecs[3] = '{32'hFFFFFFFF, 32'h12345678, 32'hEDCBA987};
    vecs[4] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000};
    vecs[5] = '{32'h0000FF00, 32'h0F0F0F0F, 32'h0F0FF00F};

    rst = 1'b1; key_valid = 0; key_last = 0; key_data = '0;
    in_valid = 0; in_data0 = '0; in_data1 = '0; out_ready = 1'b1;

    // T1 reset
    tick(); tick();
    check("rst_key_armed", key_armed0, 0);
    check("rst_out_valid", out_valid0, 0);
    check("rst_in_ready", in_ready0, 0);
    check("rst_key_ready", key_ready0, 1);
    check("rst_key_err", key_err0, 0);
    check("rst_out_data", out_data0, 0);
    rst = 1'b0;

    // Nothing passes before the first commit
    in_valid = 1'b1; in_data0 = 32'h12345678; in_data1 = 64'h1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("unarmed_in_ready", in_ready0, 0);
      check("unarmed_out_valid", out_valid0, 0);
      check("unarmed_in_ready64", in_ready1, 0);
    end
    in_valid = 1'b0;

    // T2/T3 table: full correct load, then one word through both instances
    foreach (vecs[v]) begin
      load_key(vecs[v].key, 3, 4);
      check("tbl_armed", key_armed0, 1);
      stream_one(vecs[v].din);
      check("tbl_out_valid", out_valid0, 1);
      check("tbl_out_data", out_data0, vecs[v].exp);
      check("tbl_out_data64", out_data1, exp64({~vecs[v].din, vecs[v].din}, vecs[v].key));
    end

    // T4 malformed loads leave the 0x0000FF00 key active
    load_key(32'h11223344, 1, 2);
    check("err1_pulse", key_err0, 1);
    tick();
    check("err1_pulse_end", key_err0, 0);
    check("err1_armed", key_armed0, 1);
    stream_one(32'h00000000);
    check("err1_key_kept", out_data0, 32'h0000FF00);
    load_key(32'h55667788, -1, 4);
    check("err2_pulse", key_err0, 1);
    tick();
    check("err2_pulse_end", key_err0, 0);
    stream_one(32'h00000000);
    check("err2_key_kept", out_data0, 32'h0000FF00);
    load_key(32'h00000000, 3, 4);
    check("post_err_commit_err", key_err0, 0);
    stream_one(32'hDEADBEEF);
    check("post_err_transparent", out_data0, 32'hDEADBEEF);
    tick();

    // T5 backpressure over a 16-word burst
    sent = 0;
    held = '0;
    for (int c = 0; c < 60 && rx.size() < 16; c++) begin
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (sent < 16);
      in_data0  = 32'hC0DE0000 + 32'(sent);
      in_data1  = {~in_data0, in_data0};
      #1;
      if (c == 3) held = out_data0;
      if (c > 3 && c < 8) begin
        check("bp_in_ready", in_ready0, 0);
        check("bp_out_valid", out_valid0, 1);
        check("bp_hold", out_data0, held);
      end
      acc = in_valid && in_ready0;
      if (out_valid0 && out_ready) rx.push_back(out_data0);
      tick();
      if (acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_count", 64'(rx.size()), 16);
    foreach (rx[i]) check("bp_word", rx[i], 32'hC0DE0000 + 32'(i));
    tick();

    // T6 hot reload: wrong key active, correct key loaded beneath a continuous stream
    w = 32'h0F0F00FF;
    load_key(w, 3, 4);
    for (int c = 0; c < 10; c++) begin
      d = 32'hA0000000 + 32'(c) * 32'h01010101;
      in_valid = 1'b1; in_data0 = d; in_data1 = {~d, d};
      key_valid = (c >= 2 && c <= 5);
      key_data  = 8'h00;
      key_last  = (c == 5);
      tick();
      k = (c <= 5) ? w : 32'h0;
      check("hot_out_data", out_data0, d ^ k);
      check("hot_out_data64", out_data1, exp64({~d, d}, k));
    end
    in_valid = 1'b0; key_valid = 1'b0; key_last = 1'b0;

    // Reset mid-load and mid-stream drops everything
    out_ready = 1'b0; in_valid = 1'b1; in_data0 = 32'h13572468;
    key_valid = 1'b1; key_data = 8'hAB;
    tick();
    check("mid_out_valid_before", out_valid0, 1);
    rst = 1'b1; in_valid = 1'b0; key_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("mid_rst_out_valid", out_valid0, 0);
    check("mid_rst_out_data", out_data0, 0);
    check("mid_rst_armed", key_armed0, 0);
    check("mid_rst_in_ready", in_ready0, 0);
    rst = 1'b0;

    // Random run against the reference model
    m_key = '0; m_armed = 0; m_ov = 0; m_od0 = '0; m_od1 = '0;
    beats.delete();
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data0  = $urandom;
      in_data1  = {$urandom, $urandom};
      key_valid = ($urandom_range(0, 2) == 0);
      key_data  = 8'($urandom);
      key_last  = (beats.size() == NB - 1) ? ($urandom_range(0, 7) != 0)
                                           : ($urandom_range(0, 15) == 0);
      #1;
      m_rdy = m_armed && (!m_ov || out_ready);
      check("rnd_in_ready", in_ready0, m_rdy);
      check("rnd_in_ready64", in_ready1, m_rdy);
      if (in_valid && m_rdy) begin
        m_ov  = 1'b1;
        m_od0 = in_data0 ^ m_key;
        m_od1 = exp64(in_data1, m_key);
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      m_err = 1'b0;
      if (key_valid) begin
        beats.push_back(key_data);
        if (key_last || beats.size() == NB) begin
          if (key_last && beats.size() == NB) begin
            m_key = '0;
            foreach (beats[i]) m_key = (m_key << 8) | 32'(beats[i]);
            m_armed = 1'b1;
          end else begin
            m_err = 1'b1;
          end
          beats.delete();
        end
      end
      tick();
      check("rnd_key_armed", key_armed0, m_armed);
      check("rnd_key_err", key_err0, m_err);
      check("rnd_key_err64", key_err1, m_err);
      check("rnd_out_valid", out_valid0, m_ov);
      check("rnd_out_valid64", out_valid1, m_ov);
      if (m_ov) begin
        check("rnd_out_data", out_data0, m_od0);
        check("rnd_out_data64", out_data1, m_od1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
